// File: rtl/proc_test_sequencer.sv
// Run/check sequencer: streams a program into imem, holds the core in reset,
// runs it until a jump-to-self halt or a timeout, then compares the signature.
// Ports:
//   clk, reset (async active-low), start (one-cycle pulse)
//   load_valid/load_ready/load_data/load_last : program word stream in
//   imem_we/imem_addr/imem_wdata              : instruction memory write port
//   cpu_reset (active-high), pc_out           : core control / observed PC
//   elements, expected                        : packed observed/expected signature
//   busy, done, pass, timeout, load_overflow,
//   fail_index, cycle_count                   : status and results
module proc_test_sequencer #(
    parameter int XLEN        = 64,
    parameter int NUM_ELEMS   = 8,
    parameter int INSTR_W     = 32,
    parameter int IMEM_DEPTH  = 64,
    parameter int HOLD_CYCLES = 2,
    parameter int HALT_STABLE = 3,
    parameter int MAX_CYCLES  = 1024,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int CW = $clog2(MAX_CYCLES + 1),
    localparam int IW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [INSTR_W-1:0]        load_data,
    input  logic                      load_last,
    output logic                      imem_we,
    output logic [AW-1:0]             imem_addr,
    output logic [INSTR_W-1:0]        imem_wdata,
    output logic                      cpu_reset,
    input  logic [XLEN-1:0]           pc_out,
    input  logic [NUM_ELEMS*XLEN-1:0] elements,
    input  logic [NUM_ELEMS*XLEN-1:0] expected,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic                      load_overflow,
    output logic [IW-1:0]             fail_index,
    output logic [CW-1:0]             cycle_count
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(HALT_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST, S_RUN, S_CHECK, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [XLEN-1:0] pc_prev_q, pc_prev_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   fail_q, fail_d;
    logic            pass_q, pass_d;
    logic            tmo_q, tmo_d;
    logic            ovf_q, ovf_d;
    logic            accept;
    logic [XLEN-1:0] elem_cur, exp_cur;

    always_comb begin
        elem_cur = '0;
        exp_cur  = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (idx_q == IW'(i)) begin
                elem_cur = elements[i*XLEN +: XLEN];
                exp_cur  = expected[i*XLEN +: XLEN];
            end
        end
    end

    assign load_ready    = (state_q == S_LOAD);
    assign accept        = load_ready & load_valid;
    assign imem_we       = accept;
    assign imem_addr     = addr_q;
    assign imem_wdata    = load_data;
    assign cpu_reset     = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                           (state_q == S_RST);
    assign busy          = (state_q == S_LOAD) || (state_q == S_RST) ||
                           (state_q == S_RUN)  || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign timeout       = tmo_q;
    assign load_overflow = ovf_q;
    assign fail_index    = fail_q;
    assign cycle_count   = cyc_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        cyc_d     = cyc_q;
        pc_prev_d = pc_prev_q;
        stable_d  = stable_q;
        idx_d     = idx_q;
        fail_d    = fail_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cyc_d   = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    ovf_d   = 1'b0;
                    fail_d  = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    addr_d = addr_q + AW'(1);
                    hold_d = '0;
                    if (load_last) begin
                        state_d = S_RST;
                    end else if (addr_q == AW'(IMEM_DEPTH - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = S_RST;
                    end
                end
            end
            S_RST: begin
                stable_d  = '0;
                pc_prev_d = '0;
                idx_d     = '0;
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RUN: begin
                pc_prev_d = pc_out;
                if (cyc_q != CW'(MAX_CYCLES)) begin
                    cyc_d = cyc_q + CW'(1);
                end
                // cyc_q==0 marks the first RUN cycle, whose pc_prev is stale.
                if ((cyc_q != '0) && (pc_out == pc_prev_q)) begin
                    stable_d = stable_q + SW'(1);
                end else begin
                    stable_d = '0;
                end
                if (stable_d == SW'(HALT_STABLE)) begin
                    state_d = S_CHECK;
                    idx_d   = '0;
                end else if (cyc_d == CW'(MAX_CYCLES)) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (elem_cur != exp_cur) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                    fail_d  = idx_q;
                end else if (idx_q == IW'(NUM_ELEMS - 1)) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                    fail_d  = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            hold_q    <= '0;
            cyc_q     <= '0;
            pc_prev_q <= '0;
            stable_q  <= '0;
            idx_q     <= '0;
            fail_q    <= '0;
            pass_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            cyc_q     <= cyc_d;
            pc_prev_q <= pc_prev_d;
            stable_q  <= stable_d;
            idx_q     <= idx_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Bench for proc_test_sequencer: a toy core model drives pc_out, program
// writes are checked against a queue filled as words are driven.
module tb_proc_test_sequencer;

    localparam int XLEN  = 64;
    localparam int N     = 8;
    localparam int IW_W  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int CW    = 11;
    localparam int IXW   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [IW_W-1:0]   load_data = '0;
    logic              load_last = 1'b0;
    logic              imem_we;
    logic [AW-1:0]     imem_addr;
    logic [IW_W-1:0]   imem_wdata;
    logic              cpu_reset;
    logic [XLEN-1:0]   pc_out = '0;
    logic [N*XLEN-1:0] elements = '0;
    logic [N*XLEN-1:0] expected = '0;
    logic              busy, done, pass, timeout, load_overflow;
    logic [IXW-1:0]    fail_index;
    logic [CW-1:0]     cycle_count;

    logic [XLEN-1:0]   halt_pc = 64'hC;
    logic [AW+IW_W-1:0] sbq[$];
    int compared = 0;
    int mism = 0;
    int wr_cnt = 0;

    proc_test_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .pc_out(pc_out),
        .elements(elements), .expected(expected),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .load_overflow(load_overflow), .fail_index(fail_index),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Toy core: pc walks by 4 until it reaches halt_pc, then jumps to self.
    always @(posedge clk) begin
        #1;
        if (cpu_reset) pc_out <= '0;
        else if (pc_out != halt_pc) pc_out <= pc_out + 64'd4;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [AW+IW_W-1:0] e;
            wr_cnt++;
            check("imem_write_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("imem_addr", 64'(imem_addr), 64'(e[AW+IW_W-1:IW_W]));
                check("imem_wdata", 64'(imem_wdata), 64'(e[IW_W-1:0]));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        nxt();
        start = 1'b0;
    endtask

    task automatic load(input int n, input bit with_last);
        logic [IW_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            load_valid = 1'b1;
            load_data  = w;
            load_last  = with_last && (i == n - 1);
            if (i < DEPTH) sbq.push_back({AW'(i), w});
            #1;
            if (i == 0) check("ready_in_load", 64'(load_ready), 64'd1);
            if (i == DEPTH) check("ready_after_full", 64'(load_ready), 64'd0);
            nxt();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Runs until done; hold = busy cycles with cpu_reset high,
    // tot = busy cycles with cpu_reset low (RUN + CHECK).
    task automatic run_phase(output int hold, output int tot);
        hold = 0;
        tot  = 0;
        for (int k = 0; k < 3000; k++) begin
            #1;
            if (done) break;
            if (busy && cpu_reset) hold++;
            else if (busy) tot++;
            nxt();
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic wait_cycles(input int target);
        for (int k = 0; k < 500; k++) begin
            if (cycle_count == CW'(target)) break;
            nxt();
        end
        check("cycle_reach", 64'(cycle_count), 64'(target));
    endtask

    initial begin
        int hold, tot, c0;
        logic [XLEN-1:0] tmp;
        #1;
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(load_ready), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_cycles", 64'(cycle_count), 64'd0);
        nxt();
        reset = 1'b1;
        nxt();

        for (int i = 0; i < N; i++) elements[i*XLEN +: XLEN] = {$urandom, $urandom};
        expected = elements;

        // Halting program, matching signature
        halt_pc = 64'hC;
        wr_cnt  = 0;
        pulse_start();
        load(4, 1'b1);
        run_phase(hold, tot);
        check("t1_hold", 64'(hold), 64'd2);
        check("t1_writes", 64'(wr_cnt), 64'd4);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_timeout", 64'(timeout), 64'd0);
        check("t1_check_cycles", 64'(tot - int'(cycle_count)), 64'd8);

        // Mismatch at element 5
        tmp = expected[5*XLEN +: XLEN];
        expected[5*XLEN +: XLEN] = tmp ^ 64'h100;
        pulse_start();
        check("t2_ready", 64'(load_ready), 64'd1);
        check("t2_cleared_pass", 64'(pass), 64'd0);
        check("t2_cleared_cycles", 64'(cycle_count), 64'd0);
        load(4, 1'b1);
        run_phase(hold, tot);
        check("t2_pass", 64'(pass), 64'd0);
        check("t2_fail_index", 64'(fail_index), 64'd5);
        check("t2_check_cycles", 64'(tot - int'(cycle_count)), 64'd6);
        expected = elements;

        // Never halts -> timeout
        halt_pc = '1;
        pulse_start();
        load(4, 1'b1);
        run_phase(hold, tot);
        check("t3_timeout", 64'(timeout), 64'd1);
        check("t3_pass", 64'(pass), 64'd0);
        check("t3_cycles", 64'(cycle_count), 64'd1024);
        check("t3_run_cycles", 64'(tot), 64'd1024);

        // 70 words, no last -> truncated at 64
        halt_pc = 64'hC;
        wr_cnt  = 0;
        pulse_start();
        check("t4_ovf_cleared", 64'(load_overflow), 64'd0);
        load(70, 1'b0);
        check("t4_overflow", 64'(load_overflow), 64'd1);
        run_phase(hold, tot);
        check("t4_writes", 64'(wr_cnt), 64'd64);
        check("t4_overflow_done", 64'(load_overflow), 64'd1);
        check("t4_pass", 64'(pass), 64'd1);

        // start during RUN is ignored; start in DONE restarts
        halt_pc = '1;
        pulse_start();
        load(4, 1'b1);
        wait_cycles(10);
        c0 = int'(cycle_count);
        pulse_start();
        check("t6_cycles_continue", 64'(cycle_count), 64'(c0 + 1));
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_ready", 64'(load_ready), 64'd0);
        run_phase(hold, tot);
        check("t6_timeout", 64'(timeout), 64'd1);
        check("t6_cycles", 64'(cycle_count), 64'd1024);
        halt_pc = 64'hC;
        wr_cnt  = 0;
        pulse_start();
        check("t6_restart_ready", 64'(load_ready), 64'd1);
        check("t6_restart_tmo", 64'(timeout), 64'd0);
        check("t6_restart_cycles", 64'(cycle_count), 64'd0);
        check("t6_restart_done", 64'(done), 64'd0);
        load(4, 1'b1);
        run_phase(hold, tot);
        check("t6_pass", 64'(pass), 64'd1);
        check("t6_writes", 64'(wr_cnt), 64'd4);

        // Asynchronous reset in mid-RUN
        halt_pc = '1;
        pulse_start();
        load(4, 1'b1);
        wait_cycles(50);
        #2;
        reset = 1'b0;
        #1;
        check("t5_cpu_reset", 64'(cpu_reset), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_cycles", 64'(cycle_count), 64'd0);
        nxt();
        reset = 1'b1;
        nxt();
        halt_pc = 64'hC;
        wr_cnt  = 0;
        pulse_start();
        load(4, 1'b1);
        run_phase(hold, tot);
        check("t5_hold", 64'(hold), 64'd2);
        check("t5_pass", 64'(pass), 64'd1);
        check("t5_writes", 64'(wr_cnt), 64'd4);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
